// File: rtl/serial_link_pkg.sv
// Shared types and constants for the universal-shift-register serial link.
// Used by both the receiver and the transmitter-side controller.
package serial_link_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_e;

    localparam logic MSB_FIRST = 1'b1;
    localparam logic LSB_FIRST = 1'b0;

endpackage

// File: rtl/rx_out_buf.sv
// Single-entry valid/ready holding register for received words.
// A word arriving while the entry is full and not draining is dropped.
module rx_out_buf #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             out_ready,
    input  logic             clr_err,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             overrun
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             drain;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        drain   = valid_q & out_ready;
        if (clr_err) begin
            ovr_d = 1'b0;
        end
        if (wr_en) begin
            if (!valid_q || drain) begin
                data_d  = wr_data;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign overrun   = ovr_q;

endmodule

// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver: assembles WIDTH-bit words MSB- or
// LSB-first from a qualified serial stream and buffers them for a consumer.
module serial_word_rx
    import serial_link_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             bit_valid,
    input  logic             sof,
    input  logic             msb_first,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             frame_err,
    input  logic             clr_err
);

    localparam int CW = $clog2(WIDTH + 1);

    rx_state_e        state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             order_q, order_d;
    logic             fe_q, fe_d;
    logic             word_done;
    logic [WIDTH-1:0] captured;
    logic [WIDTH-1:0] sof_word;

    always_comb begin
        if (order_q == MSB_FIRST) begin
            captured = {shreg_q[WIDTH-2:0], ser_in};
        end else begin
            captured = {ser_in, shreg_q[WIDTH-1:1]};
        end
        if (msb_first == MSB_FIRST) begin
            sof_word = {{(WIDTH-1){1'b0}}, ser_in};
        end else begin
            sof_word = {ser_in, {(WIDTH-1){1'b0}}};
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        order_d   = order_q;
        fe_d      = fe_q;
        word_done = 1'b0;
        if (clr_err) begin
            fe_d = 1'b0;
        end
        if (bit_valid) begin
            if (sof) begin
                // A sof mid-word abandons the partial word and restarts.
                if (state_q == SHIFT) begin
                    fe_d = 1'b1;
                end
                order_d = msb_first;
                shreg_d = sof_word;
                cnt_d   = CW'(1);
                state_d = SHIFT;
            end else if (state_q == SHIFT) begin
                shreg_d = captured;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    word_done = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            order_q <= MSB_FIRST;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            order_q <= order_d;
            fe_q    <= fe_d;
        end
    end

    rx_out_buf #(
        .WIDTH(WIDTH)
    ) u_out_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (word_done),
        .wr_data  (captured),
        .out_ready(out_ready),
        .clr_err  (clr_err),
        .out_data (out_data),
        .out_valid(out_valid),
        .overrun  (overrun)
    );

    assign frame_err = fe_q;

endmodule

// File: tb/tb_serial_word_rx.sv
// Bench for serial_word_rx: directed scenarios plus random traffic checked
// every cycle against a bit-list model of the receiver.
module tb_serial_word_rx;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             ser_in = 1'b0;
    logic             bit_valid = 1'b0;
    logic             sof = 1'b0;
    logic             msb_first = 1'b1;
    logic             out_ready = 1'b0;
    logic             clr_err = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             overrun;
    logic             frame_err;

    int errors = 0;
    int checks = 0;
    bit run = 1'b0;

    serial_word_rx #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .ser_in   (ser_in),
        .bit_valid(bit_valid),
        .sof      (sof),
        .msb_first(msb_first),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overrun  (overrun),
        .frame_err(frame_err),
        .clr_err  (clr_err)
    );

    always #5 clk = ~clk;

    // Model: bits are kept in arrival order and mapped to positions only
    // when the word completes.
    typedef struct {
        int               cnt;
        logic             order;
        logic [WIDTH-1:0] arr;
        logic [WIDTH-1:0] data;
        logic             valid;
        logic             ovr;
        logic             fe;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mreset();
        mdl_t r;
        r.cnt = 0;
        r.order = 1'b1;
        r.arr = '0;
        r.data = '0;
        r.valid = 1'b0;
        r.ovr = 1'b0;
        r.fe = 1'b0;
        return r;
    endfunction

    function automatic mdl_t mstep(mdl_t cur, logic bv, logic s, logic b,
                                   logic mf, logic rdy, logic clr);
        mdl_t n = cur;
        logic drain = cur.valid && rdy;
        logic done = 1'b0;
        logic fe_set = 1'b0;
        logic [WIDTH-1:0] w = '0;
        if (bv) begin
            if (s) begin
                fe_set = (cur.cnt != 0);
                n.order = mf;
                n.arr = '0;
                n.arr[0] = b;
                n.cnt = 1;
            end else if (cur.cnt != 0) begin
                n.arr[cur.cnt] = b;
                n.cnt = cur.cnt + 1;
                if (n.cnt == WIDTH) begin
                    done = 1'b1;
                    for (int i = 0; i < WIDTH; i++) begin
                        if (n.order) w[WIDTH-1-i] = n.arr[i];
                        else w[i] = n.arr[i];
                    end
                    n.cnt = 0;
                end
            end
        end
        if (clr) begin
            n.ovr = 1'b0;
            n.fe = 1'b0;
        end
        if (fe_set) n.fe = 1'b1;
        if (done) begin
            if (!cur.valid || drain) begin
                n.data = w;
                n.valid = 1'b1;
            end else begin
                n.ovr = 1'b1;
            end
        end else if (drain) begin
            n.valid = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= mreset();
        else m <= mstep(m, bit_valid, sof, ser_in, msb_first, out_ready, clr_err);
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run && !rst) begin
            chk("cyc_out_valid", {31'd0, out_valid}, {31'd0, m.valid});
            chk("cyc_out_data", {28'd0, out_data}, {28'd0, m.data});
            chk("cyc_overrun", {31'd0, overrun}, {31'd0, m.ovr});
            chk("cyc_frame_err", {31'd0, frame_err}, {31'd0, m.fe});
        end
    end

    task automatic drv(input logic bv, input logic s, input logic b, input logic mf);
        @(negedge clk);
        bit_valid = bv;
        sof = s;
        ser_in = b;
        msb_first = mf;
        clr_err = 1'b0;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic send(input logic [3:0] w, input logic mf, input int gap);
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, i == 0, mf ? w[3-i] : w[i], mf);
            if (i < 3) repeat (gap) idle();
        end
    endtask

    task automatic lit(input string n, input logic [3:0] d, input logic v,
                       input logic o, input logic f);
        chk({n, "_data"}, {28'd0, out_data}, {28'd0, d});
        chk({n, "_valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({n, "_overrun"}, {31'd0, overrun}, {31'd0, o});
        chk({n, "_frame_err"}, {31'd0, frame_err}, {31'd0, f});
    endtask

    logic [3:0] wc;

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        lit("reset", 4'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        run = 1'b1;

        out_ready = 1'b1;
        send(4'b1011, 1'b1, 0);
        idle();
        lit("msb", 4'b1011, 1'b1, 1'b0, 1'b0);
        chk("model_msb", {28'd0, m.data}, 32'hB);
        idle();
        chk("msb_one_cycle", {31'd0, out_valid}, 32'd0);

        send(4'b1101, 1'b0, 0);
        idle();
        lit("lsb", 4'b1101, 1'b1, 1'b0, 1'b0);
        chk("model_lsb", {28'd0, m.data}, 32'hD);
        idle();

        wc = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, i == 0, wc[3-i], 1'b1);
            repeat (2) idle();
        end
        chk("gap_not_yet", {31'd0, out_valid}, 32'd0);
        drv(1'b1, 1'b0, wc[0], 1'b1);
        idle();
        lit("gap", 4'b0110, 1'b1, 1'b0, 1'b0);
        idle();

        out_ready = 1'b0;
        send(4'hA, 1'b1, 0);
        send(4'h5, 1'b1, 0);
        idle();
        lit("ovr", 4'hA, 1'b1, 1'b1, 1'b0);
        chk("model_ovr", {31'd0, m.ovr}, 32'd1);
        out_ready = 1'b1;
        idle();
        out_ready = 1'b0;
        chk("ovr_drained", {31'd0, out_valid}, 32'd0);
        idle();
        clr_err = 1'b1;
        idle();
        chk("ovr_cleared", {31'd0, overrun}, 32'd0);

        send(4'h3, 1'b1, 0);
        idle();
        lit("hold3", 4'h3, 1'b1, 1'b0, 1'b0);
        wc = 4'hC;
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, i == 0, wc[3-i], 1'b1);
            if (i == 3) out_ready = 1'b1;
        end
        idle();
        lit("simul", 4'hC, 1'b1, 1'b0, 1'b0);
        idle();
        out_ready = 1'b1;

        drv(1'b1, 1'b1, 1'b1, 1'b1);
        drv(1'b1, 1'b0, 1'b0, 1'b1);
        drv(1'b1, 1'b0, 1'b1, 1'b1);
        send(4'hF, 1'b1, 0);
        idle();
        lit("frame", 4'hF, 1'b1, 1'b0, 1'b1);
        idle();
        clr_err = 1'b1;
        idle();
        chk("frame_cleared", {31'd0, frame_err}, 32'd0);

        out_ready = 1'b0;
        send(4'h6, 1'b1, 0);
        drv(1'b1, 1'b1, 1'b1, 1'b1);
        drv(1'b1, 1'b0, 1'b1, 1'b1);
        drv(1'b1, 1'b1, 1'b0, 1'b1);
        idle();
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("pre_rst_fe", {31'd0, frame_err}, 32'd1);
        #2 rst = 1'b1;
        #1 lit("async_rst", 4'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        send(4'h9, 1'b1, 0);
        idle();
        lit("post_rst", 4'h9, 1'b1, 1'b0, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bit_valid = ($urandom_range(3) != 0);
            sof = ($urandom_range(5) == 0);
            ser_in = 1'($urandom_range(1));
            msb_first = 1'($urandom_range(1));
            out_ready = ($urandom_range(2) == 0);
            clr_err = ($urandom_range(19) == 0);
        end
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

Serial-to-parallel word receiver that forms the far end of the team's universal-shift-register serial link. It samples one bit per qualified clock from a serial line driven by a shift register's `sr_out` or `sl_out`. It assembles `WIDTH`-bit words MSB-first or LSB-first and presents each completed word through a single-entry valid/ready output buffer with overrun and framing error reporting.

## Interface
- `WIDTH`, default 4: word length in bits, must be at least 2.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `ser_in` input 1: serial data bit.
- `bit_valid` input 1: `ser_in` is sampled on this edge only when `bit_valid` is 1.
- `sof` input 1: start of frame. Meaningful only with `bit_valid`=1, and marks that bit as the first bit of a word.
- `msb_first` input 1: bit order, sampled only on the `sof` bit. 1 = first bit is `data[WIDTH-1]`; 0 = first bit is `data[0]`.
- `out_data` output WIDTH: assembled word.
- `out_valid` output 1: `out_data` holds an unconsumed word.
- `out_ready` input 1: consumer accepts the word. A transfer occurs on an edge where `out_valid` and `out_ready` are both 1.
- `overrun` output 1: sticky. A completed word was dropped because the buffer was full.
- `frame_err` output 1: sticky. `sof` arrived while a word was partially assembled.
- `clr_err` input 1: synchronous clear of `overrun` and `frame_err`.

## Operation
- Reset values: state IDLE; shift register 0; bit count 0; `out_data` 0; `out_valid` 0; `overrun` 0; `frame_err` 0; latched order 1.
- Assembly FSM states:
  - IDLE: waiting for a `sof` bit.
  - SHIFT: collecting bits 2..WIDTH.
- IDLE:
  - A bit with `bit_valid`=1 and `sof`=0 is ignored.
  - A bit with `bit_valid`=1 and `sof`=1 latches `msb_first`, captures the bit, sets count to 1, and moves to SHIFT.
- SHIFT:
  - Each `bit_valid` bit is captured and the count increments. Cycles with `bit_valid`=0 hold all state, so gaps of any length are legal.
  - MSB-first capture shifts left: new bit enters at bit 0.
  - LSB-first capture shifts right: new bit enters at bit WIDTH-1.
  - When the WIDTH-th bit is captured, the word completes and the FSM returns to IDLE with count 0.
- `sof` in SHIFT:
  - The partial word is discarded and `frame_err` is set.
  - The `sof` bit is taken as bit 1 of a new word: order is re-latched, count is set to 1, and the FSM stays in SHIFT.
- Word completion:
  - If the buffer is empty, or is being drained on the same edge (`out_valid`=1 and `out_ready`=1), the completed word is loaded into `out_data` and `out_valid` is 1.
  - If the buffer is full and not being drained, the new word is dropped, `overrun` is set, and `out_data` is unchanged.
- Drain without a new word: `out_valid` goes to 0 and `out_data` holds its last value.
- `clr_err` coinciding with a new error event: the set wins.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- Reset asserted mid-word or with a full buffer: everything returns to its reset value immediately (asynchronously), and the partial word and buffered word are lost.

## Timing
- Latency: `out_valid` rises on the same edge that samples the WIDTH-th bit, so the word is visible the cycle after the last bit is presented.
- Throughput: one word per WIDTH qualified bits. Back-to-back frames are supported (a `sof` bit may immediately follow the last bit).
- No combinational path from `out_ready` to `out_valid` or `out_data`. All outputs are registered.
- Asynchronous assert of `rst`; deassert is assumed synchronous to `clk` at system level.

## Structure
- Shared package `serial_link_pkg` holds:
  - the FSM state type (IDLE, SHIFT);
  - the bit-order encoding constants MSB_FIRST=1 and LSB_FIRST=0, shared with the transmitter-side controller.
- One sub-module, `rx_out_buf`: the single-entry valid/ready holding register with overrun detection.
- Top module contains the FSM, bit counter ($clog2(WIDTH+1) bits) and shift register.

## Test plan
All scenarios use WIDTH=4.
- MSB-first: `sof`+bits 1,0,1,1 on consecutive cycles, `out_ready`=1 -> `out_data`=4'b1011, `out_valid` high one cycle, no errors.
- LSB-first: the same bits 1,0,1,1 with `msb_first`=0 -> `out_data`=4'b1101.
- Gaps: bits 0,1,1,0 MSB-first with `bit_valid` low two cycles between each bit -> 4'b0110, `out_valid` rises only after the 4th qualified bit.
- Overrun: two back-to-back words 4'hA then 4'h5 with `out_ready`=0 -> `out_data` stays 4'hA and `overrun`=1. Then `out_ready`=1 -> `out_valid` drops. `clr_err` -> `overrun`=0.
- Simultaneous drain: word 4'h3 held, then `out_ready`=1 on the same edge that 4'hC completes -> `out_data`=4'hC, `out_valid` stays 1, `overrun`=0.
- Framing and reset: `sof`, 2 bits, then `sof`+1,1,1,1 -> `frame_err`=1 and `out_data`=4'hF. Separately, `rst` asserted after 2 bits -> all outputs 0 immediately, and the next full frame is received correctly.
